// File: rtl/pcomp_gen_pkg.sv
// Shared constants for the pcomp_gen position-compare block: FSM state codes,
// DIR encodings, error codes and the guard width used for overflow-free compares.
package pcomp_gen_pkg;

  // FSM state codes
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_PRE  = 3'd1;
  localparam state_t ST_WAIT_RISE = 3'd2;
  localparam state_t ST_WAIT_FALL = 3'd3;
  localparam state_t ST_FINISHED  = 3'd4;
  localparam state_t ST_ERROR     = 3'd5;

  // DIR register encodings; code 3 falls through to positive
  localparam logic [1:0] DIR_POS  = 2'd0;
  localparam logic [1:0] DIR_NEG  = 2'd1;
  localparam logic [1:0] DIR_AUTO = 2'd2;

  // err_o codes
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_JUMP     = 2'd1;
  localparam logic [1:0] ERR_UNDERRUN = 2'd2;

  // Extra bits on top of the position width so point +/- STEP/WIDTH/DELTAP never wraps
  localparam int unsigned EXT_BITS = 2;

endpackage

// File: rtl/pcomp_gen_cmp.sv
// Direction-aware crossing comparator in the sign-extended position domain.
// neg = 0: hit when posn >= point; neg = 1: hit when posn <= point.
module pcomp_gen_cmp
  import pcomp_gen_pkg::*;
#(
  parameter int unsigned EXT_W = 32 + EXT_BITS
) (
  input  logic signed [EXT_W-1:0] posn,
  input  logic signed [EXT_W-1:0] point,
  input  logic                    neg,
  output logic                    hit
);

  // Purely combinational; the top registers every consequence of the hit
  always_comb begin
    if (neg) begin
      hit = (posn <= point);
    end else begin
      hit = (posn >= point);
    end
  end

endmodule

// File: rtl/pcomp_gen.sv
// pcomp_gen: position-compare pulse generator. Produces a pulse train on out_o as
// posn_i crosses compare points taken from START/STEP/WIDTH arithmetic or from a
// {fall, rise} table stream. All outputs are registered.
// Optional build macro PCOMP_GEN_JUMP_TOL_EN: a jump across both rise and fall
// points emits a single one-cycle pulse instead of raising a jump error.
module pcomp_gen
  import pcomp_gen_pkg::*;
#(
  parameter int unsigned POSN_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [POSN_W-1:0]     posn_i,
  input  logic [POSN_W-1:0]     START,
  input  logic [POSN_W-1:0]     STEP,
  input  logic [POSN_W-1:0]     WIDTH,
  input  logic [CNT_W-1:0]      PULSES,
  input  logic                  RELATIVE,
  input  logic [1:0]            DIR,
  input  logic [POSN_W-1:0]     DELTAP,
  input  logic                  USE_TABLE,
  input  logic [2*POSN_W-1:0]   table_data_i,
  input  logic                  table_valid_i,
  output logic                  table_ready_o,
  input  logic                  table_end_i,
  output logic                  act_o,
  output logic                  out_o,
  output logic [1:0]            err_o,
  output logic [CNT_W-1:0]      pulse_cnt_o
);

  localparam int unsigned EXT_W = POSN_W + EXT_BITS;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef logic signed [EXT_W-1:0] ext_t;

  function automatic ext_t sext(input logic [POSN_W-1:0] v);
    return ext_t'({{EXT_BITS{v[POSN_W-1]}}, v});
  endfunction

  function automatic ext_t zext(input logic [POSN_W-1:0] v);
    return ext_t'({{EXT_BITS{1'b0}}, v});
  endfunction

  // Registered state
  state_t           state;
  logic             en_prev;
  logic             dir_neg;
  ext_t             rise_pt;
  ext_t             fall_pt;

  // Next-state values
  state_t           state_nxt;
  logic             dir_neg_nxt;
  ext_t             rise_nxt;
  ext_t             fall_nxt;
  logic             act_nxt;
  logic             out_nxt;
  logic [1:0]       err_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ready_nxt;

  // Decode helpers
  logic             en_rise;
  ext_t             posn_x;
  ext_t             tbl_rise;
  ext_t             tbl_fall;
  ext_t             step_rise;
  ext_t             cmp_a_pt;
  ext_t             cmp_b_pt;
  logic             cmp_a_neg;
  logic             cmp_b_neg;
  logic             hit_a;
  logic             hit_b;
  logic             pre_ok;
  logic             pre_neg;
  logic             fall_event;
  logic             pop_req;

  assign en_rise  = enable_i & ~en_prev;
  assign posn_x   = sext(posn_i);
  assign tbl_rise = sext(table_data_i[POSN_W-1:0]);
  assign tbl_fall = sext(table_data_i[2*POSN_W-1:POSN_W]);

  // Next rise point in fixed-step mode, following the locked direction
  always_comb begin
    if (dir_neg) begin
      step_rise = rise_pt - zext(STEP);
    end else begin
      step_rise = rise_pt + zext(STEP);
    end
  end

  // Comparator operands: in WAIT_PRE the pair checks the arming band edges
  // (a: posn <= r - DELTAP, b: posn >= r + DELTAP); otherwise a = rise, b = fall.
  always_comb begin
    if (state == ST_WAIT_PRE) begin
      cmp_a_pt  = rise_pt - zext(DELTAP);
      cmp_a_neg = 1'b1;
      cmp_b_pt  = rise_pt + zext(DELTAP);
      cmp_b_neg = 1'b0;
    end else begin
      cmp_a_pt  = rise_pt;
      cmp_a_neg = dir_neg;
      cmp_b_pt  = fall_pt;
      cmp_b_neg = dir_neg;
    end
  end

  pcomp_gen_cmp #(
    .EXT_W (EXT_W)
  ) u_cmp_rise (
    .posn  (posn_x),
    .point (cmp_a_pt),
    .neg   (cmp_a_neg),
    .hit   (hit_a)
  );

  pcomp_gen_cmp #(
    .EXT_W (EXT_W)
  ) u_cmp_fall (
    .posn  (posn_x),
    .point (cmp_b_pt),
    .neg   (cmp_b_neg),
    .hit   (hit_b)
  );

  // Arming-band decision; auto mode prefers positive when both edges are met
  always_comb begin
    if (DIR == DIR_NEG) begin
      pre_ok  = hit_b;
      pre_neg = 1'b1;
    end else if (DIR == DIR_AUTO) begin
      pre_ok  = hit_a | hit_b;
      pre_neg = ~hit_a;
    end else begin
      pre_ok  = hit_a;
      pre_neg = 1'b0;
    end
  end

  // FSM next-state and registered-output next values
  always_comb begin
    state_nxt   = state;
    dir_neg_nxt = dir_neg;
    rise_nxt    = rise_pt;
    fall_nxt    = fall_pt;
    act_nxt     = act_o;
    out_nxt     = 1'b0;
    err_nxt     = err_o;
    cnt_nxt     = pulse_cnt_o;
    ready_nxt   = 1'b0;
    fall_event  = 1'b0;
    pop_req     = 1'b0;

    if (!enable_i) begin
      // Abort: err and count are kept for inspection until the next arm
      state_nxt = ST_IDLE;
      act_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en_rise) begin
            err_nxt     = ERR_NONE;
            cnt_nxt     = '0;
            act_nxt     = 1'b1;
            state_nxt   = ST_WAIT_PRE;
            dir_neg_nxt = (DIR == DIR_NEG);
            if (USE_TABLE) begin
              pop_req = 1'b1;
            end else begin
              rise_nxt = (RELATIVE ? posn_x : ext_t'(0)) + sext(START);
            end
          end
        end

        ST_WAIT_PRE: begin
          if (pre_ok) begin
            state_nxt   = ST_WAIT_RISE;
            dir_neg_nxt = pre_neg;
            // Fall point can only be derived once the direction is known
            if (!USE_TABLE) begin
              fall_nxt = pre_neg ? (rise_pt - zext(WIDTH)) : (rise_pt + zext(WIDTH));
            end
          end
        end

        ST_WAIT_RISE: begin
          if (hit_b) begin
`ifdef PCOMP_GEN_JUMP_TOL_EN
            out_nxt    = 1'b1;
            fall_event = 1'b1;
`else
            err_nxt    = ERR_JUMP;
            act_nxt    = 1'b0;
            state_nxt  = ST_ERROR;
`endif
          end else if (hit_a) begin
            out_nxt   = 1'b1;
            state_nxt = ST_WAIT_FALL;
          end
        end

        ST_WAIT_FALL: begin
          if (hit_b) begin
            fall_event = 1'b1;
          end else begin
            out_nxt = 1'b1;
          end
        end

        ST_FINISHED, ST_ERROR: begin
          act_nxt = 1'b0;
        end

        default: begin
          state_nxt = ST_IDLE;
          act_nxt   = 1'b0;
        end
      endcase

      // End of a pulse: count it, then finish or load the next compare pair
      if (fall_event) begin
        cnt_nxt = pulse_cnt_o + CNT_ONE;
        if ((PULSES != '0) && (cnt_nxt == PULSES)) begin
          state_nxt = ST_FINISHED;
          act_nxt   = 1'b0;
        end else begin
          state_nxt = ST_WAIT_RISE;
          if (USE_TABLE) begin
            pop_req = 1'b1;
          end else begin
            rise_nxt = step_rise;
            fall_nxt = dir_neg ? (step_rise - zext(WIDTH)) : (step_rise + zext(WIDTH));
          end
        end
      end

      // Table pop: strobe only when an entry is actually taken
      if (pop_req) begin
        if (table_valid_i) begin
          ready_nxt = 1'b1;
          rise_nxt  = tbl_rise;
          fall_nxt  = tbl_fall;
        end else begin
          act_nxt = 1'b0;
          if (table_end_i) begin
            state_nxt = ST_FINISHED;
          end else begin
            state_nxt = ST_ERROR;
            err_nxt   = ERR_UNDERRUN;
            out_nxt   = 1'b0;
          end
        end
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      en_prev       <= 1'b0;
      dir_neg       <= 1'b0;
      rise_pt       <= '0;
      fall_pt       <= '0;
      act_o         <= 1'b0;
      out_o         <= 1'b0;
      err_o         <= ERR_NONE;
      pulse_cnt_o   <= '0;
      table_ready_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      en_prev       <= enable_i;
      dir_neg       <= dir_neg_nxt;
      rise_pt       <= rise_nxt;
      fall_pt       <= fall_nxt;
      act_o         <= act_nxt;
      out_o         <= out_nxt;
      err_o         <= err_nxt;
      pulse_cnt_o   <= cnt_nxt;
      table_ready_o <= ready_nxt;
    end
  end

endmodule
